// File: rtl/led_drv_pkg.sv
// Shared types and helpers for the LED string driver.
// Holds the controller state encoding, the default duty resolution with its
// matching full-on duty constant, and width helpers for index/counter sizing.
package led_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } state_e;

  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned PWM_MAX      = (1 << DEF_PWM_BITS) - 1;

  // Width of a channel index, never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/led_string_driver_channel.sv
// One LED channel: target/current duty, soft ramp, forward-voltage fault
// latch and the registered PWM drive.
// Ports: clk/reset; en_i global enable; run_i counters running;
// ramp_tick_i ramp step strobe; pwm_cnt_i shared PWM phase; wr_i/wr_val_i
// target write; fault_clr_i; vf_ok_i comparator; led_on_o, fault_o
// registered; tgt_nz_c_o and ramping_c_o combinational status for the FSM.
module led_channel
  import led_drv_pkg::*;
#(
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned FAULT_CNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                run_i,
  input  logic                ramp_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wr_i,
  input  logic [PWM_BITS-1:0] wr_val_i,
  input  logic                fault_clr_i,
  input  logic                vf_ok_i,
  output logic                led_on_o,
  output logic                fault_o,
  output logic                tgt_nz_c_o,
  output logic                ramping_c_o
);

  localparam int unsigned BAD_W = cnt_w(FAULT_CNT);

  logic [PWM_BITS-1:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [BAD_W-1:0]    bad_q, bad_d, bad_smp;
  logic                fault_q, fault_d, fault_set;
  logic                led_on_q, led_on_d;

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q    <= '0;
      tgt_q    <= '0;
      bad_q    <= '0;
      fault_q  <= 1'b0;
      led_on_q <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      bad_q    <= bad_d;
      fault_q  <= fault_d;
      led_on_q <= led_on_d;
    end
  end

  // Target write, bad-sample tracking, fault latch and ramp step.
  always_comb begin
    tgt_d     = wr_i ? wr_val_i : tgt_q;
    bad_smp   = bad_q;
    fault_d   = fault_q;
    cur_d     = cur_q;
    fault_set = 1'b0;

    // Only cycles where this channel is actually lit are samples.
    if (led_on_q && !fault_q) begin
      if (vf_ok_i) begin
        bad_smp = '0;
      end else if (bad_q != BAD_W'(FAULT_CNT)) begin
        bad_smp = bad_q + BAD_W'(1);
      end
    end
    fault_set = (bad_smp == BAD_W'(FAULT_CNT));

    bad_d = bad_smp;
    if (fault_clr_i) begin
      fault_d = 1'b0;
      bad_d   = '0;
    end
    // A latching fault overrides a simultaneous clear.
    if (fault_set) begin
      fault_d = 1'b1;
      bad_d   = '0;
    end

    // Step compares against the registered target, ignoring same-cycle writes.
    if (!run_i || fault_q || fault_set) begin
      cur_d = '0;
    end else if (ramp_tick_i) begin
      if (cur_q < tgt_q) begin
        cur_d = cur_q + PWM_BITS'(1);
      end else if (cur_q > tgt_q) begin
        cur_d = cur_q - PWM_BITS'(1);
      end
    end

    led_on_d = en_i && !fault_q && (pwm_cnt_i < cur_q);
  end

  assign led_on_o    = led_on_q;
  assign fault_o     = fault_q;
  assign tgt_nz_c_o  = (tgt_q != '0);
  assign ramping_c_o = !fault_q && (cur_q != tgt_q);

endmodule

// File: rtl/led_string_driver.sv
// Digital driver for NUM_CH LED strings: shared PWM and ramp timebase,
// IDLE/RAMP/STEADY controller and duty-write decode around led_channel.
// Ports: clk; reset sync active-high; en global enable; duty_wr/duty_ch/
// duty_val target write; fault_clr; vf_ok per-channel comparator;
// led_on, fault per-channel registered; busy high while ramping.
module led_string_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned RAMP_DIV  = 16,
  parameter int unsigned FAULT_CNT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          duty_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   duty_ch,
  input  logic [PWM_BITS-1:0]           duty_val,
  input  logic                          fault_clr,
  input  logic [NUM_CH-1:0]             vf_ok,
  output logic [NUM_CH-1:0]             led_on,
  output logic [NUM_CH-1:0]             fault,
  output logic                          busy
);

  localparam int unsigned CH_W     = ch_idx_w(NUM_CH);
  localparam int unsigned RD_W     = cnt_w(RAMP_DIV - 1);
  localparam int unsigned PWM_WRAP = (1 << PWM_BITS) - 2;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [RD_W-1:0]     ramp_div_cnt_q, ramp_div_cnt_d;
  logic                run_c, ramp_tick_c;
  logic [NUM_CH-1:0]   tgt_nz_c, ramping_c;

  // State and timebase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      pwm_cnt_q      <= '0;
      ramp_div_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      pwm_cnt_q      <= pwm_cnt_d;
      ramp_div_cnt_q <= ramp_div_cnt_d;
    end
  end

  // Timebase runs only once out of IDLE with enable still high.
  always_comb begin
    run_c          = en && (state_q != IDLE);
    pwm_cnt_d      = '0;
    ramp_div_cnt_d = '0;
    ramp_tick_c    = 1'b0;
    if (run_c) begin
      pwm_cnt_d      = (pwm_cnt_q == PWM_BITS'(PWM_WRAP)) ? '0 : pwm_cnt_q + PWM_BITS'(1);
      ramp_tick_c    = (ramp_div_cnt_q == RD_W'(RAMP_DIV - 1));
      ramp_div_cnt_d = ramp_tick_c ? '0 : ramp_div_cnt_q + RD_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (|tgt_nz_c)  ? RAMP : STEADY;
        default: state_d = (|ramping_c) ? RAMP : STEADY;
      endcase
    end
  end

  // Output decode, registered alongside the state.
  always_comb begin
    busy_d = (state_d == RAMP);
  end

  assign busy = busy_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PWM_BITS  (PWM_BITS),
      .FAULT_CNT (FAULT_CNT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en_i        (en),
      .run_i       (run_c),
      .ramp_tick_i (ramp_tick_c),
      .pwm_cnt_i   (pwm_cnt_q),
      .wr_i        (duty_wr && (duty_ch == CH_W'(i))),
      .wr_val_i    (duty_val),
      .fault_clr_i (fault_clr),
      .vf_ok_i     (vf_ok[i]),
      .led_on_o    (led_on[i]),
      .fault_o     (fault[i]),
      .tgt_nz_c_o  (tgt_nz_c[i]),
      .ramping_c_o (ramping_c[i])
    );
  end

endmodule

// File: tb/tb_led_string_driver.sv
// Scoreboard bench for led_string_driver. Stimulus pushes expected
// snapshots or windowed counts; a monitor on the falling edge pops and
// compares them. Five channels so that channel 5 and 7 are out of range.
module tb_led_string_driver;

  localparam int NCH = 5;
  localparam int CHW = 3;

  logic           clk;
  logic           reset;
  logic           en;
  logic           duty_wr;
  logic [CHW-1:0] duty_ch;
  logic [7:0]     duty_val;
  logic           fault_clr;
  logic [NCH-1:0] vf_ok;
  logic [NCH-1:0] led_on;
  logic [NCH-1:0] fault;
  logic           busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          name;
    bit             is_cnt;
    bit             sel_busy;
    logic [NCH-1:0] led_mask;
    logic [NCH-1:0] led_exp;
    logic [NCH-1:0] f_mask;
    logic [NCH-1:0] f_exp;
    bit             chk_busy;
    bit             busy_exp;
    int             n;
    int             exp_cnt;
  } item_t;

  item_t sb[$];
  bit    mon_active = 1'b0;

  led_string_driver #(
    .NUM_CH    (NCH),
    .PWM_BITS  (8),
    .RAMP_DIV  (16),
    .FAULT_CNT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .duty_wr   (duty_wr),
    .duty_ch   (duty_ch),
    .duty_val  (duty_val),
    .fault_clr (fault_clr),
    .vf_ok     (vf_ok),
    .led_on    (led_on),
    .fault     (fault),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_snap(input string nm, input logic [NCH-1:0] lm, input logic [NCH-1:0] le,
                           input logic [NCH-1:0] fm, input logic [NCH-1:0] fe,
                           input bit cb, input bit be);
    item_t it;
    it.name = nm; it.is_cnt = 1'b0; it.sel_busy = 1'b0;
    it.led_mask = lm; it.led_exp = le; it.f_mask = fm; it.f_exp = fe;
    it.chk_busy = cb; it.busy_exp = be; it.n = 0; it.exp_cnt = 0;
    sb.push_back(it);
  endtask

  task automatic push_cnt(input string nm, input bit sel_b, input logic [NCH-1:0] mask,
                          input int n, input int exp_cnt);
    item_t it;
    it.name = nm; it.is_cnt = 1'b1; it.sel_busy = sel_b;
    it.led_mask = mask; it.led_exp = '0; it.f_mask = '0; it.f_exp = '0;
    it.chk_busy = 1'b0; it.busy_exp = 1'b0; it.n = n; it.exp_cnt = exp_cnt;
    sb.push_back(it);
  endtask

  // Monitor: snapshots compare at one falling edge; counts span n falling edges.
  initial begin
    item_t it;
    int    cnt;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && !sb[0].is_cnt) begin
        it = sb.pop_front();
        checks++;
        if (((led_on & it.led_mask) != it.led_exp) || ((fault & it.f_mask) != it.f_exp) ||
            (it.chk_busy && (busy != it.busy_exp))) begin
          errors++;
          $display("FAIL %s: got led_on=%b fault=%b busy=%b, want led_on=%b/%b fault=%b/%b busy=%b(chk %b)",
                   it.name, led_on, fault, busy, it.led_exp, it.led_mask, it.f_exp, it.f_mask,
                   it.busy_exp, it.chk_busy);
        end
      end
      if (sb.size() != 0) begin
        it = sb.pop_front();
        mon_active = 1'b1;
        cnt = 0;
        for (int k = 0; k < it.n; k++) begin
          if (k > 0) @(negedge clk);
          if (it.sel_busy ? busy : ((led_on & it.led_mask) != '0)) cnt++;
        end
        checks++;
        if (cnt != it.exp_cnt) begin
          errors++;
          $display("FAIL %s: counted %0d high cycles of %0d, want %0d", it.name, cnt, it.n, it.exp_cnt);
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int limit);
    int k;
    k = 0;
    while ((sb.size() != 0 || mon_active) && k < limit) begin
      tick();
      k++;
    end
    checks++;
    if (sb.size() != 0 || mon_active) begin
      errors++;
      $display("FAIL %s: scoreboard not drained after %0d cycles, %0d items left", nm, limit, sb.size());
    end
  endtask

  task automatic wait_busy_low(input string nm, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy=1 after %0d cycles, want 0", nm, limit);
    end
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
    fault_clr = 1'b0; vf_ok = '1;
    tick();
    tick();
    reset = 1'b0;
    push_snap(nm, '1, '0, '1, '0, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [CHW-1:0] ch, input logic [7:0] val);
    duty_wr = 1'b1; duty_ch = ch; duty_val = val;
    tick();
    duty_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
    fault_clr = 1'b0; vf_ok = '1;

    // All targets zero: enabled but nothing lights and nothing ramps.
    do_reset("reset_state");
    en = 1'b1;
    push_cnt("zero_tgt_busy", 1'b1, '0, 1000, 0);
    push_cnt("zero_tgt_led", 1'b0, '1, 1000, 0);
    drain("t1", 2100);

    // Ch1 to 4: busy for 65 registered cycles, then 4 of 255 lit.
    do_reset("reset_t2");
    wr(3'd1, 8'd4);
    en = 1'b1;
    push_cnt("ch1_ramp_busy", 1'b1, '0, 100, 65);
    drain("t2a", 200);
    push_cnt("ch1_duty4", 1'b0, 5'b00010, 255, 4);
    push_cnt("ch1_others_off", 1'b0, 5'b11101, 255, 0);
    drain("t2b", 600);

    // Ch0 full on, enable dropped for one cycle then a full re-ramp.
    do_reset("reset_t3");
    wr(3'd0, 8'd255);
    en = 1'b1;
    tick();
    wait_busy_low("ch0_reach_255", 4200);
    tick();
    push_snap("ch0_full_on", 5'b00001, 5'b00001, '1, '0, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    push_snap("en_drop_led_off", 5'b00001, 5'b00000, '1, '0, 1'b1, 1'b0);
    en = 1'b1;
    push_cnt("ch0_reramp_busy", 1'b1, '0, 4200, 4081);
    drain("t3", 4300);

    // Reset mid-operation also clears the targets.
    do_reset("reset_mid_op");
    en = 1'b1;
    push_cnt("post_reset_busy", 1'b1, '0, 50, 0);
    push_cnt("post_reset_led", 1'b0, '1, 50, 0);
    drain("t3b", 200);

    // Ch0 and ch2 full on; glitch then a three-sample fault on ch2.
    do_reset("reset_t4");
    wr(3'd0, 8'd255);
    wr(3'd2, 8'd255);
    en = 1'b1;
    tick();
    wait_busy_low("ch02_reach_255", 4200);
    tick();
    vf_ok = 5'b11011;
    tick();
    vf_ok = '1;
    tick(); tick(); tick();
    push_snap("glitch_no_fault", 5'b00101, 5'b00101, '1, '0, 1'b1, 1'b0);
    vf_ok = 5'b11011;
    tick();
    tick();
    push_snap("two_bad_no_fault", 5'b00100, 5'b00100, '1, '0, 1'b0, 1'b0);
    tick();
    push_snap("third_bad_fault", 5'b00100, 5'b00100, '1, 5'b00100, 1'b0, 1'b0);
    tick();
    push_snap("fault_led_off", 5'b00101, 5'b00001, '1, 5'b00100, 1'b1, 1'b0);
    vf_ok = '1;
    tick();
    push_snap("fault_held", 5'b00100, 5'b00000, '1, 5'b00100, 1'b0, 1'b0);
    drain("t4", 20);

    // Ch0 faults on the same cycle as a clear (set wins, ch2 clears),
    // then a second clear releases ch0 and ch2 starts re-ramping.
    vf_ok = 5'b11110;
    tick();
    tick();
    push_snap("ch0_two_bad", '1, 5'b00001, '1, 5'b00100, 1'b1, 1'b0);
    fault_clr = 1'b1;
    tick();
    push_snap("set_wins_clr", 5'b00101, 5'b00001, '1, 5'b00001, 1'b1, 1'b0);
    vf_ok = '1;
    tick();
    push_snap("clr_after", 5'b00101, 5'b00000, '1, 5'b00000, 1'b1, 1'b1);
    fault_clr = 1'b0;
    tick();
    push_snap("reramp_busy", 5'b00101, 5'b00000, '1, 5'b00000, 1'b1, 1'b1);
    drain("t5", 20);

    // Out-of-range channel writes change nothing.
    do_reset("reset_t6");
    en = 1'b1;
    tick(); tick();
    wr(3'd5, 8'd200);
    wr(3'd7, 8'd50);
    push_cnt("oor_busy", 1'b1, '0, 60, 0);
    push_cnt("oor_led", 1'b0, '1, 300, 0);
    drain("t6", 500);

    // Ch3 ramps toward 10, retargeted to 2 at cur=6: descends, no overshoot.
    do_reset("reset_t7");
    wr(3'd3, 8'd10);
    en = 1'b1;
    push_cnt("ch3_retarget_busy", 1'b1, '0, 250, 161);
    repeat (97) @(posedge clk);
    #1;
    wr(3'd3, 8'd2);
    drain("t7a", 300);
    push_cnt("ch3_duty2", 1'b0, 5'b01000, 255, 2);
    drain("t7b", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
